pipeline_hazard_controller: RTL and testbench

- Sequences the 5-stage TinyCPU pipeline (IF, ID, EX, MEM, WB).
- Generates the `stall` input of the PC-control block, stalls and bubbles the ID/EX boundary, and flushes wrong-path instructions after a taken jump.
- Keeps a small scoreboard of in-flight destination registers. This design has no forwarding, so RAW hazards are resolved only by stalling.
- Freezes the whole pipeline while data memory is busy.

---
 rtl/pipeline_hazard_controller_pkg.sv | 29 ++
 rtl/pipeline_hazard_controller_scoreboard.sv | 75 +++++++
 rtl/pipeline_hazard_controller.sv | 119 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller_pkg
// Brief   : TinyCPU architectural constants shared by the hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_hazard_controller_pkg;

    localparam int ARCH_REG_ADDR_W = 5;
    localparam int INSTR_TYPE_W    = 5;

    localparam logic [INSTR_TYPE_W-1:0] INSTR_ALU    = 5'd0;
    localparam logic [INSTR_TYPE_W-1:0] INSTR_LOAD   = 5'd1;
    localparam logic [INSTR_TYPE_W-1:0] INSTR_STORE  = 5'd2;
    localparam logic [INSTR_TYPE_W-1:0] INSTR_BRANCH = 5'd3;
    localparam logic [INSTR_TYPE_W-1:0] INSTR_JUMP   = 5'd4;

    // Bubble inserted by the datapath when ex_bubble is asserted (addi x0,x0,0).
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HAZARD   = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : Three-slot (EX/MEM/WB) in-flight destination tracker with
//           combinational source-register match against EX and MEM.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = ARCH_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  push_valid,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_match,
    output logic                  rs2_match
);

    logic                  ex_valid_q,  ex_valid_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  wb_valid_q,  wb_valid_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,     ex_rd_d;
    logic [REG_ADDR_W-1:0] mem_rd_q,    mem_rd_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,     wb_rd_d;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        mem_valid_d = mem_valid_q;
        wb_valid_d  = wb_valid_q;
        ex_rd_d     = ex_rd_q;
        mem_rd_d    = mem_rd_q;
        wb_rd_d     = wb_rd_q;
        if (advance) begin
            wb_valid_d  = mem_valid_q;
            wb_rd_d     = mem_rd_q;
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            ex_valid_d  = push_valid & (push_rd != '0);
            ex_rd_d     = push_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            mem_rd_q    <= '0;
            wb_rd_q     <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            mem_valid_q <= mem_valid_d;
            wb_valid_q  <= wb_valid_d;
            ex_rd_q     <= ex_rd_d;
            mem_rd_q    <= mem_rd_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    // WB writes the register file in the first half-cycle, so only EX and MEM can conflict.
    always_comb begin
        rs1_match = (rs1 != '0) &&
                    ((ex_valid_q && (ex_rd_q == rs1)) || (mem_valid_q && (mem_rd_q == rs1)));
        rs2_match = (rs2 != '0) &&
                    ((ex_valid_q && (ex_rd_q == rs2)) || (mem_valid_q && (mem_rd_q == rs2)));
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller
// Brief   : Stall / bubble / flush / freeze sequencing for the 5-stage TinyCPU.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W   = ARCH_REG_ADDR_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [INSTR_TYPE_W-1:0] id_instr_type,
    input  logic [REG_ADDR_W-1:0]   id_rs1,
    input  logic [REG_ADDR_W-1:0]   id_rs2,
    input  logic                    id_uses_rs1,
    input  logic                    id_uses_rs2,
    input  logic                    id_writes_rd,
    input  logic [REG_ADDR_W-1:0]   id_rd,
    input  logic                    ex_jump_taken,
    input  logic                    mem_busy,
    output logic                    pc_stall,
    output logic                    id_hold,
    output logic                    ex_bubble,
    output logic                    flush,
    output logic                    pipe_freeze,
    output logic [1:0]              state
);

    localparam logic [2:0] C_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    state_e     w_eff_state;
    logic [2:0] flush_cnt_q, flush_cnt_d;

    logic w_rs1_match, w_rs2_match, w_hazard;
    logic w_pc_stall, w_id_hold, w_ex_bubble, w_flush, w_freeze;
    logic w_unused_instr_type;

    assign w_unused_instr_type = ^id_instr_type;

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .advance    (~w_freeze),
        .push_valid (id_valid & id_writes_rd & ~w_ex_bubble & ~w_flush),
        .push_rd    (id_rd),
        .rs1        (id_rs1),
        .rs2        (id_rs2),
        .rs1_match  (w_rs1_match),
        .rs2_match  (w_rs2_match)
    );

    assign w_hazard = id_valid & ((id_uses_rs1 & w_rs1_match) | (id_uses_rs2 & w_rs2_match));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        w_pc_stall  = 1'b0;
        w_id_hold   = 1'b0;
        w_ex_bubble = 1'b0;
        w_flush     = 1'b0;
        w_freeze    = 1'b0;

        // The cycle memory completes behaves as the state being resumed.
        w_eff_state = state_q;
        if (state_q == ST_MEM_WAIT) begin
            w_eff_state = (flush_cnt_q != 3'd0) ? ST_FLUSH : ST_RUN;
        end

        if (mem_busy) begin
            w_freeze   = 1'b1;
            w_pc_stall = 1'b1;
            w_id_hold  = 1'b1;
            state_d    = ST_MEM_WAIT;
        end else if (ex_jump_taken) begin
            w_flush     = 1'b1;
            w_ex_bubble = 1'b1;
            flush_cnt_d = C_FLUSH_RELOAD;
            state_d     = (C_FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end else if (w_eff_state == ST_FLUSH) begin
            w_flush     = 1'b1;
            w_ex_bubble = 1'b1;
            flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
            state_d     = (flush_cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (w_hazard) begin
            w_pc_stall  = 1'b1;
            w_id_hold   = 1'b1;
            w_ex_bubble = 1'b1;
            state_d     = ST_HAZARD;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_stall    = w_pc_stall  & ~rst;
    assign id_hold     = w_id_hold   & ~rst;
    assign ex_bubble   = w_ex_bubble & ~rst;
    assign flush       = w_flush     & ~rst;
    assign pipe_freeze = w_freeze    & ~rst;
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_controller
// Brief   : Directed stimulus with a per-cycle behavioural model comparison.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;
    import pipeline_hazard_controller_pkg::*;

    localparam int FLUSH_N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd;
    logic [4:0] id_instr_type, id_rs1, id_rs2, id_rd;
    logic       ex_jump_taken, mem_busy;
    logic       pc_stall, id_hold, ex_bubble, flush, pipe_freeze;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_hazard_controller #(
        .REG_ADDR_W   (5),
        .FLUSH_CYCLES (FLUSH_N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_instr_type (id_instr_type),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .id_writes_rd  (id_writes_rd),
        .id_rd         (id_rd),
        .ex_jump_taken (ex_jump_taken),
        .mem_busy      (mem_busy),
        .pc_stall      (pc_stall),
        .id_hold       (id_hold),
        .ex_bubble     (ex_bubble),
        .flush         (flush),
        .pipe_freeze   (pipe_freeze),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: destinations in EX/MEM, remaining squash cycles, last-cycle class.
    int         m_ex = 0, m_mem = 0, m_left = 0, m_state = 0, m_ns = 0;
    bit         m_hz, m_iss;
    logic [6:0] exp_v, act_v;

    always @(negedge clk) begin
        act_v = {pc_stall, id_hold, ex_bubble, flush, pipe_freeze, state};
        exp_v = '0;
        if (rst) begin
            m_ex = 0; m_mem = 0; m_left = 0; m_state = 0;
        end else begin
            m_hz = id_valid &&
                   ((id_uses_rs1 && id_rs1 != 0 && (int'(id_rs1) == m_ex || int'(id_rs1) == m_mem)) ||
                    (id_uses_rs2 && id_rs2 != 0 && (int'(id_rs2) == m_ex || int'(id_rs2) == m_mem)));
            exp_v[1:0] = 2'(m_state);
            m_iss = 1'b0;
            if (mem_busy) begin
                exp_v[6] = 1'b1; exp_v[5] = 1'b1; exp_v[2] = 1'b1;
                m_ns = 2;
            end else if (ex_jump_taken) begin
                exp_v[4] = 1'b1; exp_v[3] = 1'b1;
                m_left = FLUSH_N - 1;
                m_ns = (m_left > 0) ? 3 : 0;
            end else if (m_left > 0) begin
                exp_v[4] = 1'b1; exp_v[3] = 1'b1;
                m_left--;
                m_ns = (m_left > 0) ? 3 : 0;
            end else if (m_hz) begin
                exp_v[6] = 1'b1; exp_v[5] = 1'b1; exp_v[4] = 1'b1;
                m_ns = 1;
            end else begin
                m_iss = 1'b1;
                m_ns = 0;
            end
            if (!mem_busy) begin
                m_mem = m_ex;
                m_ex  = (m_iss && id_valid && id_writes_rd) ? int'(id_rd) : 0;
            end
            m_state = m_ns;
        end
        check("outputs", 32'(act_v), 32'(exp_v));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit w, input int rd,
                         input bit u1, input int r1, input bit u2, input int r2);
        id_valid      = v;
        id_writes_rd  = w;
        id_rd         = 5'(rd);
        id_uses_rs1   = u1;
        id_rs1        = 5'(r1);
        id_uses_rs2   = u2;
        id_rs2        = 5'(r2);
        id_instr_type = INSTR_ALU;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Counts consecutive stall cycles seen by the currently driven consumer.
    task automatic count_stalls(output int stalls);
        stalls = 0;
        for (int g = 0; g < 12; g++) begin
            #2;
            if (!pc_stall) break;
            stalls++;
            tick();
        end
        tick();
    endtask

    task automatic dep(input string name, input int prod_rd, input int cons_rs,
                       input int gap, input int exp_stalls);
        int stalls;
        drive(1, 1, prod_rd, 1, 1, 0, 0);
        tick();
        for (int i = 0; i < gap; i++) begin
            drive(1, 1, 5 + i, 1, 1, 1, 2);
            tick();
        end
        drive(1, 1, 9, 1, 4, 1, cons_rs);
        count_stalls(stalls);
        check(name, 32'(stalls), 32'(exp_stalls));
        idle(3);
    endtask

    task automatic count_flush(input bit hazard_too, output int fl);
        fl = 0;
        for (int g = 0; g < 8; g++) begin
            #2;
            if (g == 0) check(hazard_too ? "jump_hz_pc_stall" : "jump_pc_stall",
                              32'(pc_stall), 32'd0);
            if (!flush) break;
            fl++;
            tick();
            ex_jump_taken = 1'b0;
            drive(0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int fl, frz, stalls;
        rst = 1'b1;
        mem_busy = 1'b1;
        ex_jump_taken = 1'b0;
        drive(1, 1, 3, 1, 3, 0, 0);
        tick();
        #2;
        check("rst_outputs", 32'({pc_stall, id_hold, ex_bubble, flush, pipe_freeze, state}), 32'd0);
        tick();
        rst = 1'b0;
        #2;
        check("post_rst_freeze", 32'(pipe_freeze), 32'd1);
        check("post_rst_state", 32'(state), 32'd0);
        tick();
        mem_busy = 1'b0;
        idle(3);

        dep("raw_gap0_stalls", 3, 3, 0, 2);
        dep("raw_gap1_stalls", 3, 3, 1, 1);
        dep("raw_gap2_stalls", 3, 3, 2, 0);
        dep("r0_no_stall", 0, 0, 0, 0);
        dep("raw_rs2_r7", 7, 7, 0, 2);

        // Plain taken jump.
        drive(0, 0, 0, 0, 0, 0, 0);
        ex_jump_taken = 1'b1;
        count_flush(1'b0, fl);
        check("jump_flush_cycles", 32'(fl), 32'(FLUSH_N));
        idle(3);

        // Jump coinciding with a RAW hazard: jump wins.
        drive(1, 1, 3, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 3, 0, 0);
        ex_jump_taken = 1'b1;
        count_flush(1'b1, fl);
        check("jump_hz_flush_cycles", 32'(fl), 32'(FLUSH_N));
        idle(3);

        // Memory busy for 3 cycles in the middle of a 2-cycle RAW stall.
        drive(1, 1, 3, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 3, 0, 0);
        #2;
        check("mem_hz_first_stall", 32'(pc_stall), 32'd1);
        tick();
        mem_busy = 1'b1;
        frz = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            frz += int'(pipe_freeze);
            if (i == 1) check("memwait_state", 32'(state), 32'd2);
            tick();
        end
        mem_busy = 1'b0;
        check("mem_freeze_cycles", 32'(frz), 32'd3);
        count_stalls(stalls);
        check("mem_hz_remaining_stalls", 32'(stalls), 32'd1);
        idle(3);

        // Memory busy right after a taken jump with one squash cycle pending.
        drive(0, 0, 0, 0, 0, 0, 0);
        ex_jump_taken = 1'b1;
        tick();
        ex_jump_taken = 1'b0;
        mem_busy = 1'b1;
        tick();
        tick();
        mem_busy = 1'b0;
        fl = 0;
        for (int g = 0; g < 8; g++) begin
            #2;
            if (!flush) break;
            fl++;
            tick();
        end
        check("memwait_flush_cycles", 32'(fl), 32'd1);
        check("run_after_flush", 32'(state), 32'd0);
        tick();
        idle(2);

        // Reset in the middle of a flush.
        ex_jump_taken = 1'b1;
        tick();
        ex_jump_taken = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_midflush_outputs", 32'({pc_stall, id_hold, ex_bubble, flush, pipe_freeze, state}), 32'd0);
        tick();
        rst = 1'b0;
        #2;
        check("after_rst_flush", 32'(flush), 32'd0);
        check("after_rst_state", 32'(state), 32'd0);
        tick();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
